// File: rtl/nf_wb_arb.sv
// Write-back arbiter: merges in-order ALU results and returning loads onto one register-file
// write port, buffering colliding loads and killing stale ones. Optional stats: NF_WB_STATS_EN.
module nf_wb_arb #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_we,
  input  logic [4:0]  alu_wa,
  input  logic [31:0] alu_wd,
  input  logic        lsu_vld,
  output logic        lsu_rdy,
  input  logic [4:0]  lsu_wa,
  input  logic [31:0] lsu_wd,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic        we3,
  output logic        stall_req,
`ifdef NF_WB_STATS_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] kill_cnt,
`endif
  output logic [31:0] pend_mask
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [4:0]       ent_wa_q [DEPTH];
  logic [31:0]      ent_wd_q [DEPTH];
  logic [DEPTH-1:0] live_q, live_d, waw_hit;
  logic [AW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q, count_d;

  logic hs, empty, pop, pass, push, in_dead;
  logic [CW-1:0] kill_inc;

  assign lsu_rdy   = (count_q < CW'(DEPTH));
  assign stall_req = (count_q >= CW'(DEPTH - 1));
  assign empty     = (count_q == '0);
  assign hs        = lsu_vld & lsu_rdy;
  assign pop       = ~alu_we & ~empty;
  assign pass      = ~alu_we & empty & hs;
  assign push      = hs & ~pass;
  // The ALU write is younger than any load, so a same-cycle load to the same register is stale.
  assign in_dead   = (lsu_wa == 5'd0) | (alu_we & (alu_wa == lsu_wa));

  always_comb begin
    waw_hit   = '0;
    pend_mask = '0;
    kill_inc  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (alu_we && live_q[i] && (ent_wa_q[i] == alu_wa)) waw_hit[i] = 1'b1;
      if (live_q[i]) pend_mask[ent_wa_q[i]] = 1'b1;
      kill_inc = kill_inc + CW'(waw_hit[i]);
    end
    pend_mask[0] = 1'b0;
    if (hs && in_dead) kill_inc = kill_inc + CW'(1);
  end

  always_comb begin
    live_d = live_q & ~waw_hit;
    if (pop)  live_d[head_q] = 1'b0;
    if (push) live_d[tail_q] = ~in_dead;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_wa_q[i] <= '0;
        ent_wd_q[i] <= '0;
      end
      live_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we3     <= 1'b0;
      wa3     <= '0;
      wd3     <= '0;
    end else begin
      live_q  <= live_d;
      count_q <= count_d;
      if (push) begin
        ent_wa_q[tail_q] <= lsu_wa;
        ent_wd_q[tail_q] <= lsu_wd;
        tail_q           <= tail_q + AW'(1);
      end
      if (pop) head_q <= head_q + AW'(1);
      if (alu_we) begin
        we3 <= (alu_wa != 5'd0);
        wa3 <= alu_wa;
        wd3 <= alu_wd;
      end else if (pop) begin
        // A live entry never targets x0, so its live bit alone is the write enable.
        we3 <= live_q[head_q];
        wa3 <= ent_wa_q[head_q];
        wd3 <= ent_wd_q[head_q];
      end else if (pass) begin
        we3 <= ~in_dead;
        wa3 <= lsu_wa;
        wd3 <= lsu_wd;
      end else begin
        we3 <= 1'b0;
      end
    end
  end

`ifdef NF_WB_STATS_EN
  logic [32:0] stall_sum, kill_sum;
  assign stall_sum = {1'b0, stall_cnt} + 33'(stall_req);
  assign kill_sum  = {1'b0, kill_cnt} + 33'(kill_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      kill_cnt  <= '0;
    end else begin
      stall_cnt <= stall_sum[32] ? '1 : stall_sum[31:0];
      kill_cnt  <= kill_sum[32] ? '1 : kill_sum[31:0];
    end
  end
`endif

endmodule
